// File: rtl/camac_write_assembler.sv
// ============================================================================
// Module   : camac_write_assembler
// Purpose  : Gathers three ISA bytes into a 24-bit word, launches it onto the
//            CAMAC W lines and times the S1 strobe with a busy/done handshake.
//            Optional CAMAC_AUTO_GO_EN: a lane-2 write completing the mask
//            launches the cycle without go.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module camac_write_assembler #(
    parameter int STROBE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic [1:0]  byte_sel,
    input  logic        wr_strobe,
    input  logic        go,
    output logic [23:0] w,
    output logic        s1,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_SETUP    = 2'd1;
    localparam logic [1:0] c_STROBE   = 2'd2;
    localparam logic [1:0] c_HOLD     = 2'd3;
    localparam logic [7:0] c_CNT_LOAD = 8'(STROBE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_cnt;
    logic [23:0] r_hold;
    logic [2:0]  r_mask;
    logic [23:0] r_w;
    logic        r_s1, r_busy, r_done, r_err;

    logic        w_idle;
    logic        w_capture;
    logic [2:0]  w_lane_bit;
    logic [2:0]  w_mask_upd;
    logic [23:0] w_hold_upd;
    logic        w_go_ok;
    logic        w_auto;
    logic        w_launch;
    logic        w_reject;
    logic        w_s1_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;

    // The byte lands before go is judged, so the last byte and go may coincide.
    always_comb begin
        w_idle     = (r_state == c_IDLE);
        w_capture  = w_idle && wr_strobe && (byte_sel != 2'd3);
        w_lane_bit = 3'b000;
        w_hold_upd = r_hold;
        if (w_capture) begin
            case (byte_sel)
                2'd0: begin w_lane_bit = 3'b001; w_hold_upd[7:0]   = data; end
                2'd1: begin w_lane_bit = 3'b010; w_hold_upd[15:8]  = data; end
                2'd2: begin w_lane_bit = 3'b100; w_hold_upd[23:16] = data; end
                default: ;
            endcase
        end
        w_mask_upd = r_mask | w_lane_bit;
        w_go_ok    = go && (w_mask_upd == 3'b111);
`ifdef CAMAC_AUTO_GO_EN
        w_auto     = w_capture && (byte_sel == 2'd2) && (r_mask == 3'b011);
`else
        w_auto     = 1'b0;
`endif
        w_launch   = w_idle && (w_go_ok || w_auto);
        w_reject   = w_idle && go && !w_go_ok;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_launch) w_state_nxt = c_SETUP;
            c_SETUP:  w_state_nxt = c_STROBE;
            c_STROBE: if (r_cnt == 8'd0) w_state_nxt = c_HOLD;
            c_HOLD:   w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they arrive registered.
    always_comb begin
        w_s1_nxt   = (w_state_nxt == c_STROBE);
        w_busy_nxt = (w_state_nxt != c_IDLE);
        w_done_nxt = (r_state == c_HOLD);
        w_err_nxt  = w_reject;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_s1    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s1    <= w_s1_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 8'd0;
            r_hold <= 24'd0;
            r_mask <= 3'b000;
            r_w    <= 24'd0;
        end else begin
            if (r_state == c_SETUP) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == c_STROBE) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
            r_hold <= w_hold_upd;
            r_mask <= w_launch ? 3'b000 : w_mask_upd;
            if (w_launch) begin
                r_w <= w_hold_upd;
            end
        end
    end

    assign w    = r_w;
    assign s1   = r_s1;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_camac_write_assembler.sv
// ============================================================================
// Module   : tb_camac_write_assembler
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a cycle-age reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_camac_write_assembler;

    localparam int c_N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data;
    logic [1:0]  byte_sel;
    logic        wr_strobe, go;
    logic [23:0] w;
    logic        s1, busy, done, err;

    logic        s_rst_n;
    logic [7:0]  s_data;
    logic [1:0]  s_byte_sel;
    logic        s_wr_strobe, s_go;
    logic [23:0] s_w;
    logic        s_s1, s_busy, s_done, s_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    camac_write_assembler #(.STROBE_CYCLES(c_N)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .byte_sel(byte_sel),
        .wr_strobe(wr_strobe), .go(go), .w(w), .s1(s1), .busy(busy),
        .done(done), .err(err)
    );

    camac_write_assembler #(.STROBE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(s_rst_n), .data(s_data), .byte_sel(s_byte_sel),
        .wr_strobe(s_wr_strobe), .go(s_go), .w(s_w), .s1(s_s1), .busy(s_busy),
        .done(s_done), .err(s_err)
    );

    // Reference model: tracks the age of the running cycle in clock edges.
    logic [7:0]  m_hold [3];
    bit          m_mask [3];
    logic [23:0] m_w;
    bit          m_active, m_done, m_err;
    int          m_age;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin m_hold[i] = 8'h00; m_mask[i] = 1'b0; end
        m_w = 24'd0; m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_age = 0;
    endfunction

    function automatic void model_step(input bit wr, input logic [1:0] sel,
                                       input logic [7:0] d, input bit g);
        bit was_011;
        bit auto_fire;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_active) begin
            m_age++;
            if (m_age == c_N + 2) begin m_active = 1'b0; m_done = 1'b1; end
        end else begin
            was_011   = m_mask[0] && m_mask[1] && !m_mask[2];
            auto_fire = 1'b0;
            if (wr && sel != 2'd3) begin
                m_hold[sel] = d;
                m_mask[sel] = 1'b1;
`ifdef CAMAC_AUTO_GO_EN
                auto_fire = (sel == 2'd2) && was_011;
`endif
            end
            if ((g && m_mask[0] && m_mask[1] && m_mask[2]) || auto_fire) begin
                m_w = {m_hold[2], m_hold[1], m_hold[0]};
                for (int i = 0; i < 3; i++) m_mask[i] = 1'b0;
                m_active = 1'b1;
                m_age = 0;
            end else if (g) begin
                m_err = 1'b1;
            end
        end
    endfunction

    function automatic logic [27:0] model_out();
        bit e_s1;
        e_s1 = m_active && (m_age >= 1) && (m_age <= c_N);
        return {m_active, e_s1, m_done, m_err, m_w};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit wr, input logic [1:0] sel, input logic [7:0] d, input bit g);
        wr_strobe = wr; byte_sel = sel; data = d; go = g;
        @(posedge clk);
        model_step(wr, sel, d, g);
        #1;
        wr_strobe = 1'b0; go = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_strobe = 1'b0; go = 1'b0; byte_sel = 2'd0; data = 8'h00;
        #20;
        chk("reset_outputs", {busy, s1, done, err, w}, 32'd0);
        chk("reset_mask", dut.r_mask, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  sel;
        logic [7:0]  d;
        bit          g;
        logic [27:0] exp;   // {busy, s1, done, err, w}
    } vec_t;

    vec_t tbl [13];

    initial begin
        int busy_cnt, s1_cnt;
        bit seen_done;
        logic [27:0] act;

        tbl[0]  = '{1'b1, 2'd2, 8'h33, 1'b0, {4'b0000, 24'h000000}};
        tbl[1]  = '{1'b1, 2'd0, 8'h11, 1'b0, {4'b0000, 24'h000000}};
        tbl[2]  = '{1'b1, 2'd1, 8'h22, 1'b0, {4'b0000, 24'h000000}};
        tbl[3]  = '{1'b0, 2'd0, 8'h00, 1'b1, {4'b1000, 24'h332211}};
        tbl[4]  = '{1'b0, 2'd0, 8'h00, 1'b0, {4'b1100, 24'h332211}};
        tbl[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, {4'b1100, 24'h332211}};
        tbl[6]  = '{1'b0, 2'd0, 8'h00, 1'b0, {4'b1100, 24'h332211}};
        tbl[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, {4'b1100, 24'h332211}};
        tbl[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, {4'b1000, 24'h332211}};
        tbl[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, {4'b0010, 24'h332211}};
        tbl[10] = '{1'b0, 2'd0, 8'h00, 1'b1, {4'b0001, 24'h332211}};
        tbl[11] = '{1'b0, 2'd0, 8'h00, 1'b0, {4'b0000, 24'h332211}};
        tbl[12] = '{1'b1, 2'd3, 8'h99, 1'b0, {4'b0000, 24'h332211}};

        s_rst_n = 1'b0; s_wr_strobe = 1'b0; s_go = 1'b0; s_byte_sel = 2'd0; s_data = 8'h00;

        // Basic write from the vector table.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].wr, tbl[i].sel, tbl[i].d, tbl[i].g);
            chk($sformatf("vec[%0d]", i), {4'd0, busy, s1, done, err, w}, {4'd0, tbl[i].exp});
        end
        chk("basic_mask_after", dut.r_mask, 32'd0);

        // Incomplete mask rejects go.
        do_reset();
        cyc(1'b1, 2'd0, 8'hAA, 1'b0);
        cyc(1'b1, 2'd2, 8'hBB, 1'b0);
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        chk("incomplete_err", {4'd0, busy, s1, done, err, w}, {4'd0, 4'b0001, 24'h0});
        chk("incomplete_mask", dut.r_mask, 32'b101);
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        chk("incomplete_err_one_cycle", err, 32'd0);

        // Writes and go while busy are ignored.
        do_reset();
        cyc(1'b1, 2'd2, 8'hA5, 1'b0);
        cyc(1'b1, 2'd0, 8'hA5, 1'b0);
        cyc(1'b1, 2'd1, 8'hA5, 1'b0);
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        chk("busy_in_strobe", s1, 32'd1);
        cyc(1'b1, 2'd1, 8'hFF, 1'b1);
        chk("busy_write_w", w, 32'hA5A5A5);
        chk("busy_write_err", err, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            cyc(1'b0, 2'd0, 8'h00, 1'b0);
            if (done) seen_done = 1'b1;
        end
        chk("busy_done_seen", seen_done, 32'd1);
        chk("busy_mask_after", dut.r_mask, 32'd0);
        chk("busy_hold_lane1", dut.r_hold[15:8], 32'hA5);

        // Final byte and go together, then reset during the second s1 cycle.
        do_reset();
        cyc(1'b1, 2'd0, 8'h01, 1'b0);
        cyc(1'b1, 2'd1, 8'h02, 1'b0);
        cyc(1'b1, 2'd2, 8'h7E, 1'b1);
        chk("simul_launch", {busy, w}, {7'd0, 1'b1, 24'h7E0201});
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        chk("second_s1_cycle", s1, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {busy, s1, w}, 32'd0);
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        chk("post_reset_go_err", {busy, err}, 32'b01);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)),
                8'($urandom), ($urandom_range(0, 99) < 25));
            act = {busy, s1, done, err, w};
            chk($sformatf("rand[%0d]", i), {4'd0, act}, {4'd0, model_out()});
        end

        // STROBE_CYCLES=1 instance.
        @(negedge clk);
        s_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_wr_strobe = 1'b1; s_byte_sel = 2'(i); s_data = 8'(8'h40 + i);
            @(posedge clk); #1;
        end
        s_wr_strobe = 1'b0;
`ifdef CAMAC_AUTO_GO_EN
        chk("n1_auto_launch", s_busy, 32'd1);
`else
        chk("n1_no_auto_launch", s_busy, 32'd0);
        s_go = 1'b1;
        @(posedge clk); #1;
        s_go = 1'b0;
`endif
        chk("n1_w", s_w, 32'h424140);
        busy_cnt = s_busy ? 1 : 0;
        s1_cnt = s_s1 ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            busy_cnt += s_busy ? 1 : 0;
            s1_cnt += s_s1 ? 1 : 0;
        end
        chk("n1_busy_cycles", busy_cnt, 32'd3);
        chk("n1_s1_cycles", s1_cnt, 32'd1);
        chk("n1_no_err", s_err, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/camac_write_assembler.md
# camac_write_assembler

Write-path counterpart of the ISA→CAMAC read multiplexer on the sm2201 interface board. Collects three byte writes from the 8-bit ISA data bus into a 24-bit holding register, then, on command, drives the CAMAC W1–W24 write lines and generates a timed S1 strobe with a busy/done handshake back to the ISA decode logic. The block sits between the ISA address/strobe decoder and the CAMAC dataway drivers.

## Interface
Parameters:
- STROBE_CYCLES, 4: S1 high time in clk cycles, legal range 1–255.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data  in  8  ISA data bus byte.
- byte_sel  in  2  lane for the byte: 0 = W1–W8, 1 = W9–W16, 2 = W17–W24, 3 = no lane (write is ignored).
- wr_strobe  in  1  one-cycle pulse, already synchronized to clk; captures data into lane byte_sel.
- go  in  1  one-cycle pulse requesting a CAMAC write cycle.
- w  out  24  CAMAC write lines, driven from a launch shadow register.
- s1  out  1  CAMAC S1 strobe, active high.
- busy  out  1  a write cycle is in progress.
- done  out  1  one-cycle pulse at the end of a cycle.
- err  out  1  one-cycle pulse when go is rejected.

## Operation
- Holding register hold[23:0] and lane-loaded mask mask[2:0]. A wr_strobe in IDLE with byte_sel<3 writes data into that lane and sets the lane's mask bit.
- FSM states:
  - IDLE: go is accepted only when the mask is complete (111).
  - SETUP: always 1 cycle.
  - STROBE: lasts STROBE_CYCLES cycles.
  - HOLD: always 1 cycle, then return to IDLE.
- Accepted go: w <= hold (the only time w changes), mask <= 000, state <= SETUP. hold keeps its contents.
- go in IDLE with an incomplete mask: err pulses for 1 cycle. The state, w and the mask do not change.
- wr_strobe and go in the same IDLE cycle: the byte is captured first, and go is evaluated against the updated mask. This lets the final byte and go arrive together.
- wr_strobe, go and byte_sel=3 are ignored while busy. hold, mask and w do not change, and err is not asserted.
- Strobe counter: 8-bit down-counter loaded with STROBE_CYCLES-1 on SETUP→STROBE. STROBE→HOLD when the counter reaches 0.
- Outputs:
  - s1 = 1 only in STROBE.
  - busy = 1 in SETUP, STROBE and HOLD.
  - done asserts on the edge HOLD→IDLE.
- All outputs are registered.
- Reset (asynchronous, at any time, including mid-strobe) forces:
  - w=0, s1=0, busy=0, done=0, err=0
  - hold=0, mask=000, counter=0, state=IDLE
- The first clock edge after rst_n rises behaves as a normal IDLE cycle.

## Timing
Edge E0 samples an accepted go.
- After E0: busy=1 and w is valid, with s1=0. W has 1 cycle of setup before S1.
- After E1: s1=1 for exactly STROBE_CYCLES cycles.
- After E(1+STROBE_CYCLES): s1=0 (HOLD). W stays stable for 1 hold cycle.
- After E(2+STROBE_CYCLES): busy=0 and done=1 for 1 cycle.
- busy is high for STROBE_CYCLES+2 cycles.
- A new go is accepted at the earliest in the cycle where done=1, provided the mask has been reloaded to 111. Back-to-back cycles therefore need fresh writes to all three lanes (or CAMAC_AUTO_GO_EN).
- err is asserted the cycle after the rejected go.
- Write latency: hold and mask update on the edge that samples wr_strobe.

## Configuration
- CAMAC_AUTO_GO_EN defined:
  - A wr_strobe to lane 2 in IDLE, which completes the mask (mask was 011), launches a write cycle exactly as an accepted go on that same edge.
  - A lane-2 write that leaves the mask incomplete does not launch a cycle and does not assert err.
  - go still works as specified.
- CAMAC_AUTO_GO_EN undefined: only go launches a cycle. A lane-2 write only loads the lane.

## Test plan
- Basic write: load lanes 0/1/2 with 0x11/0x22/0x33, then go. Required: w=0x332211 one cycle before s1 rises; s1 high for 4 cycles; busy high for 6 cycles; done pulses once; mask reads 000 afterwards.
- Incomplete mask: load lanes 0 and 2 only, then go. Required: err pulses for 1 cycle; busy, s1 and w (still 0) unchanged; mask stays 101.
- Writes during busy: start a cycle with 0xA5A5A5; while in STROBE, write 0xFF to lane 1 and pulse go. Required: w stays 0xA5A5A5; no err; after done, mask=000 and hold lane 1 still 0xA5.
- Simultaneous last byte and go: load lanes 0/1, then in one cycle assert wr_strobe with lane 2 = 0x7E and go. Required: cycle launches with w[23:16]=0x7E.
- Reset mid-strobe: assert rst_n=0 on the second s1 cycle. Required: s1, busy and w go to 0 immediately without waiting for clk; after release, go without reloading produces err.
- STROBE_CYCLES=1 build, with CAMAC_AUTO_GO_EN defined: write lanes 0, 1, 2 in order. Required: the lane-2 write alone launches the cycle; s1 is high for exactly 1 cycle; busy is high for 3 cycles.
